// File: rtl/atm_display_pkg.sv
// Shared constants and types for the ATM display path.
// The binary-to-BCD converter and its digit-correction cell use this package.
package atm_display_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'd9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Largest value representable with the given number of decimal digits.
  function automatic longint unsigned max_val(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
// This keeps the digit in decimal range after the following left shift.
module bcd_digit_adjust
  import atm_display_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble converter with a start/busy/done handshake.
// Results above the display range saturate to all nines and raise overflow.
module binary_to_bcd_converter
  import atm_display_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [BIN_W-1:0]             bin_in,
  output logic                         busy,
  output logic                         done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                         overflow
);

  localparam int              BCD_W   = BCD_DIGIT_W * DIGITS;
  localparam int              CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(BIN_W - 1);
  localparam longint unsigned MAX_VAL = max_val(DIGITS);
  localparam logic [BCD_W-1:0] SAT    = {DIGITS{BCD_NINE}};

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [CNT_W-1:0] cnt;
  logic             ovf_flag;

  logic [BCD_W-1:0] adjusted;
  logic [BCD_W-1:0] shifted;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit    (scratch [d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (adjusted[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The corrected scratch's top bit falls off here; saturation covers overflow.
  assign shifted = (adjusted << 1) | BCD_W'(shreg[BIN_W-1]);

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values, e.g. the final write of bcd_out sees the same
  // shifted value that scratch captures on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin_in;
            scratch  <= '0;
            cnt      <= '0;
            ovf_flag <= (64'(bin_in) > MAX_VAL);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          shreg   <= shreg << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd_out  <= ovf_flag ? SAT : shifted;
            overflow <= ovf_flag;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/binary_to_bcd_converter.md
# binary_to_bcd_converter

Sequential double-dabble converter that turns an unsigned binary amount (account balance, withdrawal amount, PIN entry) into packed BCD digits for the ATM display path. It sits directly upstream of the per-digit BCD-to-seven-segment decoders. Each 4-bit nibble of `bcd_out` drives one decoder's digit input. A start/busy/done handshake lets the ATM control FSM request a conversion and know when the digits are valid.

## Interface
- `BIN_W`, default 14: width of the binary input.
- `DIGITS`, default 4: number of BCD digits produced. `MAX_VAL = 10^DIGITS - 1` (9999 at defaults).
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `start`: input, 1 bit. Conversion request, sampled only in IDLE.
- `bin_in`: input, BIN_W bits. Unsigned binary value, captured on the accepting edge.
- `busy`: output, 1 bit. High while a conversion is in progress.
- `done`: output, 1 bit. One-cycle pulse; `bcd_out` and `overflow` are valid and updated.
- `bcd_out`: output, 4*DIGITS bits. Packed BCD; digit 0 (units) is in bits [3:0], the most significant digit is in the top nibble.
- `overflow`: output, 1 bit. Last accepted `bin_in` exceeded `MAX_VAL`.

## Operation
- FSM states are IDLE and SHIFT.
- **IDLE, start=1:**
  - Load the shift register with `bin_in`.
  - Clear the BCD scratch register to 0.
  - Clear the bit counter to 0.
  - Latch an overflow flag equal to (`bin_in` > `MAX_VAL`).
  - Go to SHIFT.
- **IDLE, start=0:** hold.
- **Each SHIFT cycle:**
  - In every scratch digit, add 3 if the digit is ≥5; otherwise leave it unchanged.
  - Shift the corrected scratch left by 1, bringing in the shift register MSB.
  - Shift the shift register left by 1.
  - Increment the counter.
- **Counter at BIN_W-1 in SHIFT:** this is the final shift.
  - Write the resulting scratch to `bcd_out`, or all digits = 9 if the overflow flag is set.
  - Copy the overflow flag to the `overflow` output.
  - Assert `done`.
  - Return to IDLE.
- `start` while in SHIFT is ignored. It is not queued.
- `bin_in` changes after the accepting edge have no effect.
- `bcd_out` and `overflow` hold their values between `done` pulses.
- Overflow saturation value is all nines, e.g. 16'h9999 at the defaults.
- Overflow can only occur when 2^BIN_W - 1 > `MAX_VAL`. Otherwise the compare is constant false.
- Scratch register width is 4*DIGITS bits. Do not extend it; overflow is handled by the saturation above.
- **Reset (asserted at any time, including mid-conversion):**
  - Aborts immediately; state goes to IDLE.
  - `busy`, `done` and `overflow` go to 0.
  - `bcd_out` goes to 0, shift register and counter go to 0.
  - No `done` is produced for the aborted request.

## Timing
- Accepting edge E0: `start`=1 while in IDLE. `busy` goes 1 after E0.
- Shift edges are E1..E(BIN_W).
- After edge E(BIN_W):
  - `bcd_out` and `overflow` are updated.
  - `done`=1 and `busy`=0.
- Latency from the accepting edge to `done` visible is BIN_W cycles (14 at defaults).
- `busy` is high for exactly BIN_W cycles.
- `done` is high for exactly one cycle; it is cleared at the next edge.
- Back-to-back: `start` may be high in the `done` cycle. That edge is accepted (FSM is in IDLE), so throughput is one conversion per BIN_W+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `atm_display_pkg`:
  - `BCD_DIGIT_W` = 4.
  - FSM state enum (IDLE, SHIFT).
  - Helper function for `MAX_VAL` (10^DIGITS - 1).
  - Constant `BCD_NINE` = 4'd9.
- Sub-module `bcd_digit_adjust`: combinational, 4-bit in and 4-bit out, out = in ≥5 ? in+3 : in. Instantiated DIGITS times via generate.
- Counter width is $clog2(BIN_W).

## Test plan
- Reset released, `start` with `bin_in`=0 → `done` after 14 cycles, `bcd_out`=16'h0000, `overflow`=0, `busy` high exactly 14 cycles.
- `bin_in`=1234 → `bcd_out`=16'h1234. `bin_in`=9999 → 16'h9999, `overflow`=0. Also 5, 50, 500 → 16'h0005, 16'h0050, 16'h0500, exercising the add-3 corrections.
- `bin_in`=10000, then 16383 → `bcd_out`=16'h9999, `overflow`=1. A following conversion of 42 → 16'h0042 with `overflow`=0.
- `start` pulsed with `bin_in`=7 while busy converting 321 → the single result is 16'h0321; no second `done` appears.
- `start` held high continuously with `bin_in` stepping 0..20 → a `done` every 15 cycles, each result matching the value present at its accepting edge.
- `rst_n` asserted at cycle 6 of a conversion → all outputs 0 immediately. After release no `done` appears until a new `start`; the next conversion of 88 → 16'h0088.
